jbi_min_rq_rdq_ctl: RTL and testbench
=====================================

JBI_MIN_RQ_RDQ_CTL -- requirements
Module: jbi_min_rq_rdq_ctl

Interface
REQ-001 SHALL have parameter DEPTH, default 16 (`JBI_RDQ_DEPTH), meaning number of RDQ buffer entries.
REQ-002 SHALL have parameter AW, default 4 (`JBI_RDQ_ADDR_WIDTH), meaning RDQ address width; DEPTH == 2**AW.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port push, input, 1: write one entry into the RDQ this cycle.
REQ-006 SHALL have port push_last, input, 1: qualifies push; the entry ends a transaction.
REQ-007 SHALL have port pop, input, 1: read one entry from the RDQ this cycle.
REQ-008 SHALL have port pop_last, input, 1: qualifies pop; the entry ends a transaction.
REQ-009 SHALL have port rdq_wr_en, output, 1: write enable to the RDQ buffer.
REQ-010 SHALL have port rdq_waddr, output, AW: write address to the RDQ buffer.
REQ-011 SHALL have port rdq_rd_en, output, 1: read enable to the RDQ buffer.
REQ-012 SHALL have port rdq_raddr, output, AW: read address to the RDQ buffer.
REQ-013 SHALL have port rdq_rdata_vld, output, 1: RDQ read data valid (one cycle after rdq_rd_en).
REQ-014 SHALL have port rdq_count, output, AW+1: occupied entries, 0..DEPTH.
REQ-015 SHALL have port rdq_full, output, 1: rdq_count == DEPTH.
REQ-016 SHALL have port rdq_empty, output, 1: rdq_count == 0.
REQ-017 SHALL have port rdq_line_space, output, 1: at least 4 free entries (room for a full 64B line).
REQ-018 SHALL have port rdq_tran_avail, output, 1: at least one complete transaction resident.
REQ-019 SHALL have port rdq_ovf_err, output, 1: sticky; a push was made while full.
REQ-020 SHALL have port rdq_unf_err, output, 1: sticky; a pop was made while empty.

Function
REQ-021 Push acceptance: push_acc = push & ~rdq_full. rdq_wr_en SHALL equal push_acc combinationally; rdq_waddr SHALL equal the registered wptr.
REQ-022 Pop acceptance: pop_acc = pop & ~rdq_empty. rdq_rd_en SHALL equal pop_acc combinationally; rdq_raddr SHALL equal the registered rptr.
REQ-023 wptr SHALL increment by 1 mod DEPTH on push_acc; rptr SHALL increment by 1 mod DEPTH on pop_acc; both wrap from DEPTH-1 to 0.
REQ-024 rdq_count SHALL be registered: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither occur.
REQ-025 rdq_full, rdq_empty and rdq_line_space (DEPTH - rdq_count >= 4) SHALL be decoded from registered rdq_count.
REQ-026 Simultaneous push and pop while full SHALL accept the pop only. Simultaneous push and pop while empty SHALL accept the push only; there is no bypass.
REQ-027 Transaction counter tcnt (AW+1 bits) SHALL be +1 on push_acc&push_last, -1 on pop_acc&pop_last, and unchanged when both occur. rdq_tran_avail = (tcnt != 0).
REQ-028 rdq_rdata_vld SHALL be rdq_rd_en delayed by one clk (buffer read latency 1).
REQ-029 A rejected push SHALL set rdq_ovf_err; a rejected pop SHALL set rdq_unf_err. Both SHALL stay set until rst. A rejected operation SHALL NOT change pointers or counters.
REQ-030 push_last without push, and pop_last without pop, SHALL be ignored.

Reset
REQ-031 While rst = 1 at a clk edge, the following SHALL be cleared: wptr = 0, rptr = 0, rdq_count = 0, tcnt = 0, rdq_rdata_vld = 0, rdq_ovf_err = 0, rdq_unf_err = 0.
REQ-032 While rst is asserted, the outputs SHALL be rdq_empty = 1, rdq_full = 0, rdq_line_space = 1, rdq_tran_avail = 0, and rdq_wr_en = rdq_rd_en = 0 regardless of push/pop.
REQ-033 Reset asserted mid-transaction SHALL discard all contents; the first accepted push after reset SHALL write address 0.

Structure
REQ-034 DEPTH, AW and the line size (4) SHALL come from the shared jbi.h defines. No local copies.
REQ-035 The block SHALL be a single module with no sub-modules. It SHALL be instantiated beside the RDQ buffer in the min RQ, with rdq_* driving the buffer's write and read ports.

Verification
REQ-036 Reset, then 16 pushes (last on #4, #8, #12, #16) -> waddr 0..15, count 16, full = 1, tran_avail = 1, line_space = 0 after push #13.
REQ-037 From full, push + pop in the same cycle -> wr_en = 0, rd_en = 1 at raddr 0, count 15, ovf_err = 1.
REQ-038 From empty, push + pop in the same cycle -> wr_en = 1 at waddr 0, rd_en = 0, count 1, unf_err = 1.
REQ-039 Run 40 push/pop pairs at 8 entries steady occupancy -> pointers wrap 15 -> 0, count stays 8, rdata_vld tracks rd_en +1 cycle.
REQ-040 Push 3 entries with push_last on #3, pop 2, assert rst, then push 1 -> count 1, tcnt 0 (tran_avail = 0), waddr 0, error flags 0.
REQ-041 push_last + pop_last accepted in the same cycle with tcnt = 1 -> tcnt stays 1, tran_avail stays 1.

Source files
------------

// File: rtl/jbi_min_rq_rdq_ctl_pkg.sv
// rtl/jbi_min_rq_rdq_ctl_pkg.sv - shared RDQ sizing constants for the min RQ
package jbi_min_rq_rdq_ctl_pkg;

    // Number of RDQ buffer entries
    localparam int JBI_RDQ_DEPTH      = 16;
    // RDQ address width; JBI_RDQ_DEPTH == 2**JBI_RDQ_ADDR_WIDTH
    localparam int JBI_RDQ_ADDR_WIDTH = 4;
    // Entries occupied by one full 64B line
    localparam int JBI_RDQ_LINE_ENTRIES = 4;

endpackage

// File: rtl/jbi_min_rq_rdq_ctl.sv
// rtl/jbi_min_rq_rdq_ctl.sv - RDQ pointer, occupancy and transaction-count control
module jbi_min_rq_rdq_ctl
    import jbi_min_rq_rdq_ctl_pkg::*;
#(
    parameter int DEPTH = JBI_RDQ_DEPTH,
    parameter int AW    = JBI_RDQ_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_last,
    input  logic          pop,
    input  logic          pop_last,
    output logic          rdq_wr_en,
    output logic [AW-1:0] rdq_waddr,
    output logic          rdq_rd_en,
    output logic [AW-1:0] rdq_raddr,
    output logic          rdq_rdata_vld,
    output logic [AW:0]   rdq_count,
    output logic          rdq_full,
    output logic          rdq_empty,
    output logic          rdq_line_space,
    output logic          rdq_tran_avail,
    output logic          rdq_ovf_err,
    output logic          rdq_unf_err
);

    localparam logic [AW:0] COUNT_FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] COUNT_LINE_MAX  = (AW+1)'(DEPTH - JBI_RDQ_LINE_ENTRIES);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   tcnt_q, tcnt_d;
    logic          rdata_vld_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          push_acc;
    logic          pop_acc;
    logic          tcnt_inc;
    logic          tcnt_dec;

    // Status decode from registered occupancy; reset forces the idle view
    always_comb begin
        rdq_full       = ~rst & (count_q == COUNT_FULL);
        rdq_empty      = rst | (count_q == '0);
        rdq_line_space = rst | (count_q <= COUNT_LINE_MAX);
        rdq_tran_avail = ~rst & (tcnt_q != '0);
        rdq_count      = count_q;
        rdq_waddr      = wptr_q;
        rdq_raddr      = rptr_q;
        rdq_rdata_vld  = rdata_vld_q;
        rdq_ovf_err    = ovf_q;
        rdq_unf_err    = unf_q;
    end

    // Accept push unless full, pop unless empty; no bypass from push to pop
    always_comb begin
        push_acc  = push & ~rdq_full & ~rst;
        pop_acc   = pop & ~rdq_empty & ~rst;
        rdq_wr_en = push_acc;
        rdq_rd_en = pop_acc;
        tcnt_inc  = push_acc & push_last;
        tcnt_dec  = pop_acc & pop_last;
    end

    // Next-state for pointers, counters and sticky error flags
    always_comb begin
        wptr_d  = push_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_acc ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        tcnt_d = tcnt_q;
        case ({tcnt_inc, tcnt_dec})
            2'b10:   tcnt_d = tcnt_q + 1'b1;
            2'b01:   tcnt_d = tcnt_q - 1'b1;
            default: tcnt_d = tcnt_q;
        endcase
        ovf_d = ovf_q | (push & rdq_full);
        unf_d = unf_q | (pop & rdq_empty);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            tcnt_q      <= '0;
            rdata_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            tcnt_q      <= tcnt_d;
            rdata_vld_q <= pop_acc;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_jbi_min_rq_rdq_ctl.sv
// tb/tb_jbi_min_rq_rdq_ctl.sv - self-checking bench for jbi_min_rq_rdq_ctl
module tb_jbi_min_rq_rdq_ctl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          push, push_last, pop, pop_last;
    logic          rdq_wr_en, rdq_rd_en, rdq_rdata_vld;
    logic [AW-1:0] rdq_waddr, rdq_raddr;
    logic [AW:0]   rdq_count;
    logic          rdq_full, rdq_empty, rdq_line_space, rdq_tran_avail;
    logic          rdq_ovf_err, rdq_unf_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of resident entries (each holds its "last" flag)
    bit m_q[$];
    int m_wptr, m_rptr;
    bit m_ovf, m_unf, m_vld;

    jbi_min_rq_rdq_ctl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_last(push_last), .pop(pop), .pop_last(pop_last),
        .rdq_wr_en(rdq_wr_en), .rdq_waddr(rdq_waddr),
        .rdq_rd_en(rdq_rd_en), .rdq_raddr(rdq_raddr),
        .rdq_rdata_vld(rdq_rdata_vld), .rdq_count(rdq_count),
        .rdq_full(rdq_full), .rdq_empty(rdq_empty),
        .rdq_line_space(rdq_line_space), .rdq_tran_avail(rdq_tran_avail),
        .rdq_ovf_err(rdq_ovf_err), .rdq_unf_err(rdq_unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_tcnt();
        int n = 0;
        foreach (m_q[i]) if (m_q[i]) n++;
        return n;
    endfunction

    // One cycle: drive inputs, compare mid-cycle against the model, clock, update the model
    task automatic step(input bit p, input bit pl, input bit r, input bit rl);
        bit pa, ra, full, empty;
        push = p; push_last = pl; pop = r; pop_last = rl;
        #3;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        pa = p && !full;
        ra = r && !empty;
        chk("wr_en", rdq_wr_en, pa);
        chk("rd_en", rdq_rd_en, ra);
        chk("waddr", rdq_waddr, m_wptr);
        chk("raddr", rdq_raddr, m_rptr);
        chk("count", rdq_count, m_q.size());
        chk("full", rdq_full, full);
        chk("empty", rdq_empty, empty);
        chk("line_space", rdq_line_space, (DEPTH - m_q.size()) >= 4);
        chk("tran_avail", rdq_tran_avail, m_tcnt() != 0);
        chk("rdata_vld", rdq_rdata_vld, m_vld);
        chk("ovf_err", rdq_ovf_err, m_ovf);
        chk("unf_err", rdq_unf_err, m_unf);
        @(posedge clk);
        if (p && full)  m_ovf = 1;
        if (r && empty) m_unf = 1;
        if (ra) begin void'(m_q.pop_front()); m_rptr = (m_rptr + 1) % DEPTH; end
        if (pa) begin m_q.push_back(pl); m_wptr = (m_wptr + 1) % DEPTH; end
        m_vld = ra;
        #1;
    endtask

    // Reset for one cycle with push/pop held high; outputs must show the idle view
    task automatic do_reset();
        rst = 1; push = 1; push_last = 1; pop = 1; pop_last = 1;
        #3;
        chk("rst_wr_en", rdq_wr_en, 0);
        chk("rst_rd_en", rdq_rd_en, 0);
        chk("rst_empty", rdq_empty, 1);
        chk("rst_full", rdq_full, 0);
        chk("rst_line_space", rdq_line_space, 1);
        chk("rst_tran_avail", rdq_tran_avail, 0);
        @(posedge clk);
        m_q.delete(); m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0; m_vld = 0;
        #1;
        rst = 0;
    endtask

    task automatic pop_one();
        step(0, 0, 1, (m_q.size() != 0) ? m_q[0] : 1'b0);
    endtask

    initial begin
        rst = 1; push = 0; push_last = 0; pop = 0; pop_last = 0;
        @(posedge clk); #1;
        do_reset();

        // Fill: 16 pushes, last on every fourth
        for (int i = 1; i <= DEPTH; i++) step(1, (i % 4) == 0, 0, 0);
        chk("fill_full", rdq_full, 1);
        chk("fill_count", rdq_count, DEPTH);

        // Full: push+pop together takes the pop only and flags overflow
        step(1, 0, 1, 0);
        chk("full_both_ovf", rdq_ovf_err, 1);
        chk("full_both_count", rdq_count, DEPTH - 1);

        // Drain to empty, then push+pop together takes the push only
        while (m_q.size() != 0) pop_one();
        step(1, 0, 1, 0);
        chk("empty_both_unf", rdq_unf_err, 1);
        chk("empty_both_count", rdq_count, 1);

        // Steady occupancy of 8 with 40 push/pop pairs, pointers wrap
        do_reset();
        for (int i = 0; i < 8; i++) step(1, i[0], 0, 0);
        for (int i = 0; i < 40; i++) step(1, $urandom_range(0, 1), 1, m_q[0]);
        step(0, 0, 0, 0);
        chk("steady_count", rdq_count, 8);

        // Random traffic; pop_last follows the stored flag of the head entry
        for (int i = 0; i < 400; i++) begin
            bit p, r;
            p = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            step(p, $urandom_range(0, 1), r, (m_q.size() != 0) ? m_q[0] : 1'b0);
        end
        for (int i = 0; i < 20; i++) pop_one();
        step(0, 0, 0, 0);

        // Reset mid-transaction discards contents
        do_reset();
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        pop_one(); pop_one();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("post_rst_count", rdq_count, 1);
        chk("post_rst_tran", rdq_tran_avail, 0);
        chk("post_rst_raddr", rdq_raddr, 0);

        // Same-cycle push_last and pop_last with one transaction resident
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);
        chk("both_last_tran", rdq_tran_avail, 1);

        // Qualifiers without their strobes are ignored
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
